pattern_scan_engine: RTL and testbench
======================================

// Module: pattern_scan_engine
// PURPOSE
//  Memory-side coprocessor for program 3 (5-bit pattern search). It shares data memory with
//  the 9-bit CPU and hangs off the same start/done handshake as top_level.
//  On start it reads the pattern from mem[32][7:3] and scans mem[0..31] as a 256-bit string
//  (byte 0 = MSBs). It then writes three counts to mem[33..35] and raises done.
//  The CPU's software result must match these counts; this block is the golden hardware reference.
// PARAMETERS
//  STR_BASE  8'd0   first address of the 32-byte search string
//  STR_LEN   32     number of string bytes scanned
//  PAT_ADDR  8'd32  pattern byte address; pattern = bits [7:3]
//  RES_ADDR  8'd33  results go to RES_ADDR+0 (in-byte count), +1 (byte count), +2 (crossing count)
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous, active-low reset
//  start        in   1  request; sampled high in IDLE or DONE
//  done         out  1  high while results are valid; held until the next accepted start
//  mem_addr     out  8  data memory address (combinational from state/index)
//  mem_rd_data  in   8  data memory read data; asynchronous read, same cycle as mem_addr
//  mem_wr_en    out  1  one-cycle write strobe
//  mem_wr_data  out  8  write data
// BEHAVIOUR
//  Reset: state=IDLE; done=0; mem_wr_en=0; mem_addr=0; counters/pat/carry=0. No memory write follows reset.
//  FSM: IDLE -start-> LD_PAT -> SCAN(x STR_LEN) -> WR_B -> WR_O -> WR_S -> DONE -start-> LD_PAT.
//  LD_PAT: mem_addr=PAT_ADDR; at the edge pat<=mem_rd_data[7:3]; clear counters, idx and carry.
//  SCAN i: mem_addr=STR_BASE+i; w={carry[3:0],mem_rd_data}.
//    ctb += number of b[4:0],b[5:1],b[6:2],b[7:3] that equal pat (0..4).
//    cto += 1 if any of those four match.
//    cts += matches among the 8 windows w[11:7]..w[4:0]; for i==0 only the 4 in-byte windows count.
//    carry<=b[3:0].
//  Widths: all counters are 8-bit. Maxima are ctb=128, cto=32, cts=252, so no saturation logic.
//  WR_B/WR_O/WR_S: mem_wr_en=1, addr RES_ADDR+0/+1/+2, data ctb/cto/cts; one write each.
//  Latency: start sampled at edge E0 -> done=1 after edge E0+STR_LEN+5 (37 cycles at default).
//  done=1 only in DONE; it drops the cycle after an accepted start. mem_wr_en=0 outside WR_*.
//  start in IDLE/DONE held high for several cycles: only the first edge starts a run.
//    Re-arming requires returning to DONE.
//  rst_n low mid-run: immediate IDLE, no partial result writes, done=0.
// CONFIGURATION
//  PATSCAN_ABORT_EN defined: start=1 in LD_PAT/SCAN/WR_* aborts the run.
//    Next state is LD_PAT, counters clear, and remaining result writes are skipped.
//  Not defined: start is ignored while busy; the run completes unchanged.
// STRUCTURE
//  prog3_pkg: state enum scan_state_t {IDLE,LD_PAT,SCAN,WR_B,WR_O,WR_S,DONE},
//    address constants, PAT_W=5.
//  Sub-module window_match (combinational).
//    In: w[11:0], pat[4:0], first. Out: nb[2:0] in-byte count, any, nx[3:0] crossing count.
//  Top: FSM, idx counter, accumulators and memory port mux.
// TESTING
//  T1 mem[0..31]=0x00, mem[32]=0x00 -> mem[33..35]=128,32,252; done 37 cycles after start.
//  T2 mem[0..31]=0x55, pat=5'b10101 (mem[32]=0xA8) -> 64,32,126.
//  T3 mem[0..31]=0x00, pat=5'b11111 -> 0,0,0. Bytes 0xFF with the same pattern -> 128,32,252.
//  T4 crossing only: mem[0]=0x07, mem[1]=0xC0, rest 0, pat=5'b11111 -> 0,0,1.
//  T5 rst_n low during SCAN idx=10 -> done=0, no writes to 33..35, restart gives correct T1 results.
//  T6 start pulse at SCAN idx=5.
//    With PATSCAN_ABORT_EN: counts are recomputed from scratch and done comes 37 cycles after the second start.
//    Without it: done at the original time, results unaffected.
//  All tests: mem_wr_en pulses exactly 3 times per run, at addresses 33,34,35 only.

Source files
------------

// File: rtl/prog3_pkg.sv
// rtl/prog3_pkg.sv - shared types and address map for the 5-bit pattern scan engine
package prog3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_PAT,
        SCAN,
        WR_B,
        WR_O,
        WR_S,
        DONE
    } scan_state_t;

    localparam int          PAT_W    = 5;
    localparam int          STR_LEN  = 32;
    localparam int          IDX_W    = $clog2(STR_LEN);
    localparam logic [7:0]  STR_BASE = 8'd0;
    localparam logic [7:0]  PAT_ADDR = 8'd32;
    localparam logic [7:0]  RES_ADDR = 8'd33;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STR_LEN - 1);

endpackage

// File: rtl/window_match.sv
// rtl/window_match.sv - counts 5-bit pattern hits in one byte plus the byte-boundary windows
module window_match
    import prog3_pkg::*;
(
    input  logic [11:0]      w,
    input  logic [PAT_W-1:0] pat,
    input  logic             first,
    output logic [2:0]       nb,
    output logic             any,
    output logic [3:0]       nx
);

    // w[7:0] is the current byte, w[11:8] the low nibble of the previous byte.
    // In-byte windows are w[4:0]..w[7:3]; crossing windows are w[8:4]..w[11:7].
    always_comb begin
        nb = 3'd0;
        nx = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (w[k +: PAT_W] == pat) begin
                nb = nb + 3'd1;
            end
            if (!first && (w[k + 4 +: PAT_W] == pat)) begin
                nx = nx + 4'd1;
            end
        end
        any = (nb != 3'd0);
    end

endmodule

// File: rtl/pattern_scan_engine.sv
// rtl/pattern_scan_engine.sv - hardware pattern counter over mem[0..31]; optional PATSCAN_ABORT_EN lets start abort a busy run
module pattern_scan_engine
    import prog3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [IDX_W-1:0] idx;
    logic [PAT_W-1:0] pat;
    logic [3:0]       carry;
    logic [7:0]       ctb;
    logic [7:0]       cto;
    logic [7:0]       cts;
    logic [2:0]       nb;
    logic             any;
    logic [3:0]       nx;
    logic             abort;

`ifdef PATSCAN_ABORT_EN
    assign abort = start && (state != IDLE) && (state != DONE);
`else
    assign abort = 1'b0;
`endif

    window_match u_window_match (
        .w     ({carry, mem_rd_data}),
        .pat   (pat),
        .first (idx == '0),
        .nb    (nb),
        .any   (any),
        .nx    (nx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory port mux; an abort redirects to LD_PAT and kills any pending write.
    always_comb begin
        state_next  = state;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (state)
            IDLE: begin
                if (start) state_next = LD_PAT;
            end
            LD_PAT: begin
                mem_addr   = PAT_ADDR;
                state_next = SCAN;
            end
            SCAN: begin
                mem_addr = STR_BASE + 8'(idx);
                if (idx == LAST_IDX) state_next = WR_B;
            end
            WR_B: begin
                mem_addr    = RES_ADDR;
                mem_wr_en   = 1'b1;
                mem_wr_data = ctb;
                state_next  = WR_O;
            end
            WR_O: begin
                mem_addr    = RES_ADDR + 8'd1;
                mem_wr_en   = 1'b1;
                mem_wr_data = cto;
                state_next  = WR_S;
            end
            WR_S: begin
                mem_addr    = RES_ADDR + 8'd2;
                mem_wr_en   = 1'b1;
                mem_wr_data = cts;
                state_next  = DONE;
            end
            DONE: begin
                if (start) state_next = LD_PAT;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = LD_PAT;
            mem_wr_en  = 1'b0;
        end
    end

    // Pattern load, string index and match accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat   <= '0;
            idx   <= '0;
            carry <= 4'd0;
            ctb   <= 8'd0;
            cto   <= 8'd0;
            cts   <= 8'd0;
        end else if (abort) begin
            idx   <= '0;
            carry <= 4'd0;
            ctb   <= 8'd0;
            cto   <= 8'd0;
            cts   <= 8'd0;
        end else if (state == LD_PAT) begin
            pat   <= mem_rd_data[7:3];
            idx   <= '0;
            carry <= 4'd0;
            ctb   <= 8'd0;
            cto   <= 8'd0;
            cts   <= 8'd0;
        end else if (state == SCAN) begin
            ctb   <= ctb + 8'(nb);
            cto   <= cto + 8'(any);
            cts   <= cts + 8'(nb) + 8'(nx);
            carry <= mem_rd_data[3:0];
            idx   <= idx + 1'b1;
        end
    end

    // Done rises one cycle after entering DONE so results are already in memory, and drops on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state == DONE) && (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_pattern_scan_engine.sv
// tb/tb_pattern_scan_engine.sv - directed self-checking bench for pattern_scan_engine
module tb_pattern_scan_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [0:255];
    int         cyc = 0;
    int         wr_cnt = 0;
    int         bad_addr = 0;
    int         checks = 0;
    int         failures = 0;

    pattern_scan_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_cnt <= wr_cnt + 1;
            if (mem_addr < 8'd33 || mem_addr > 8'd35) bad_addr <= bad_addr + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] b, input logic [7:0] p);
        for (int i = 0; i < 32; i++) mem[i] = b;
        mem[32] = p;
        mem[33] = 8'hEE;
        mem[34] = 8'hEE;
        mem[35] = 8'hEE;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_done"}, int'(done), 1);
    endtask

    task automatic run(input string tag, input int eb, input int eo, input int es);
        int c0;
        int w0;
        int b0;
        w0 = wr_cnt;
        b0 = bad_addr;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        check({tag, "_done_drop"}, int'(done), 0);
        wait_done(tag);
        check({tag, "_lat"}, cyc - c0, 37);
        check({tag, "_ctb"}, int'(mem[33]), eb);
        check({tag, "_cto"}, int'(mem[34]), eo);
        check({tag, "_cts"}, int'(mem[35]), es);
        check({tag, "_nwr"}, wr_cnt - w0, 3);
        check({tag, "_badaddr"}, bad_addr - b0, 0);
    endtask

    initial begin
        int c0;
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", int'(done), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_wr", wr_cnt, 0);

        fill(8'h00, 8'h00);
        run("t1", 128, 32, 252);
        fill(8'h55, 8'hA8);
        run("t2", 64, 32, 126);
        fill(8'h00, 8'hF8);
        run("t3a", 0, 0, 0);
        fill(8'hFF, 8'hF8);
        run("t3b", 128, 32, 252);
        fill(8'h00, 8'hF8);
        mem[0] = 8'h07;
        mem[1] = 8'hC0;
        run("t4", 0, 0, 1);

        // T5: asynchronous reset in the middle of the scan
        fill(8'h00, 8'h00);
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("t5_idx10_addr", int'(mem_addr), 10);
        rst_n = 1'b0;
        #1;
        check("t5_rst_done", int'(done), 0);
        check("t5_rst_addr", int'(mem_addr), 0);
        repeat (40) @(posedge clk);
        #1;
        check("t5_nwr", wr_cnt - w0, 0);
        check("t5_res", int'(mem[33]), 8'hEE);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("t5_idle_nwr", wr_cnt - w0, 0);
        check("t5_idle_done", int'(done), 0);
        run("t5r", 128, 32, 252);

        // T6: start pulse while scanning index 5
        fill(8'h00, 8'h00);
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6_idx5_addr", int'(mem_addr), 5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t6");
`ifdef PATSCAN_ABORT_EN
        check("t6_lat", cyc - c0, 44);
`else
        check("t6_lat", cyc - c0, 37);
`endif
        check("t6_ctb", int'(mem[33]), 128);
        check("t6_cto", int'(mem[34]), 32);
        check("t6_cts", int'(mem[35]), 252);
        check("t6_nwr", wr_cnt - w0, 3);
        repeat (5) @(posedge clk);
        #1;
        check("t6_done_hold", int'(done), 1);
        check("badaddr_total", bad_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
